vga_scaled_window: RTL and testbench

// - Maps a SRC_W x SRC_H frame buffer (e.g. 160x144) onto the VGA raster with integer upscaling by SCALE, placed at (WIN_X0,WIN_Y0).
// - Sits between the VGA timing controller and the VRAM read port.
// - Generates VRAM read addresses incrementally, with no multiplier.
// - Aligns HSync/VSync with the RAM read latency, fills the border with a colour and offers a colour-bar test mode.

---
 rtl/vga_scaled_window.sv | 224 ++++++++++++++++++++++
 tb/tb_vga_scaled_window.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaled_window.sv
// vga_scaled_window: places an integer-upscaled frame buffer on the VGA
// raster, drives VRAM read addresses and aligns syncs with the RAM latency.
module vga_scaled_window #(
   parameter int   SRC_W       = 160,
   parameter int   SRC_H       = 144,
   parameter int   SCALE       = 4,
   parameter int   WIN_X0      = 320,
   parameter int   WIN_Y0      = 72,
   parameter int   ADDR_WIDTH  = 15,
   parameter int   DATA_WIDTH  = 8,
   parameter int   RAM_LATENCY = 1,
   parameter logic HSYNC_IDLE  = 1'b0,
   parameter logic VSYNC_IDLE  = 1'b0
) (
   input  logic                  i_clkPixel,
   input  logic                  i_reset,
   input  logic                  i_active,
   input  logic [15:0]           i_x,
   input  logic [15:0]           i_y,
   input  logic                  i_hSync,
   input  logic                  i_vSync,
   input  logic [DATA_WIDTH-1:0] i_vramData,
   input  logic                  i_testPattern,
   input  logic [7:0]            i_borderColor,
   output logic [ADDR_WIDTH-1:0] o_vramAddr,
   output logic [2:0]            o_red,
   output logic [2:0]            o_green,
   output logic [1:0]            o_blue,
   output logic                  o_hSync,
   output logic                  o_vSync,
   output logic                  o_frameStart
);

   localparam int L       = RAM_LATENCY + 2;
   localparam int P       = L - 1;
   localparam int WIN_W   = SRC_W * SCALE;
   localparam int WIN_H   = SRC_H * SCALE;
   localparam int BAR_LEN = SCALE * SRC_W / 8;
   localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int BW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

   localparam logic [15:0] X_LO   = 16'(WIN_X0);
   localparam logic [15:0] X_HI   = 16'(WIN_X0 + WIN_W);
   localparam logic [15:0] X_LAST = 16'(WIN_X0 + WIN_W - 1);
   localparam logic [15:0] Y_LO   = 16'(WIN_Y0);
   localparam logic [15:0] Y_HI   = 16'(WIN_Y0 + WIN_H);

   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(SRC_W);
   localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);
   localparam logic [SW-1:0]         SUB_MAX  = SW'(SCALE - 1);
   localparam logic [SW-1:0]         ONE_S    = SW'(1);
   localparam logic [BW-1:0]         BAR_MAX  = BW'(BAR_LEN - 1);
   localparam logic [BW-1:0]         ONE_B    = BW'(1);

   logic                  in_win;
   logic                  frame_start;
   logic                  first_px;
   logic                  last_px;

   logic [ADDR_WIDTH-1:0] row_base;
   logic [ADDR_WIDTH-1:0] row_base_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [SW-1:0]         sub_x;
   logic [SW-1:0]         sub_x_nxt;
   logic [SW-1:0]         sub_y;
   logic [SW-1:0]         sub_y_nxt;
   logic [BW-1:0]         bar_cnt;
   logic [BW-1:0]         bar_cnt_nxt;
   logic [2:0]            bar_idx;
   logic [2:0]            bar_idx_nxt;
   logic                  mode_q;
   logic                  mode_nxt;

   logic [P-1:0]          p_act;
   logic [P-1:0]          p_win;
   logic [P-1:0]          p_hs;
   logic [P-1:0]          p_vs;
   logic [P-1:0]          p_fs;
   logic [P-1:0]          p_mode;
   logic [2:0]            p_bar [P];

   logic [7:0]            bar_color;
   logic [7:0]            pix;

   // Classify the incoming raster position.
   always_comb begin
      in_win      = i_active
                    && (i_x >= X_LO) && (i_x < X_HI)
                    && (i_y >= Y_LO) && (i_y < Y_HI);
      frame_start = (i_x == 16'd0) && (i_y == 16'd0);
      first_px    = in_win && (i_x == X_LO);
      last_px     = in_win && (i_x == X_LAST);
   end

   // Incremental address, sub-pixel and colour-bar counters.
   always_comb begin
      row_base_nxt = frame_start ? '0 : row_base;
      sub_y_nxt    = frame_start ? '0 : sub_y;
      sub_x_nxt    = frame_start ? '0 : sub_x;
      bar_cnt_nxt  = frame_start ? '0 : bar_cnt;
      bar_idx_nxt  = frame_start ? '0 : bar_idx;
      mode_nxt     = frame_start ? i_testPattern : mode_q;
      addr_nxt     = o_vramAddr;
      if (first_px) begin
         addr_nxt    = row_base_nxt;
         sub_x_nxt   = '0;
         bar_cnt_nxt = '0;
         bar_idx_nxt = '0;
      end else if (in_win) begin
         if (sub_x == SUB_MAX) begin
            sub_x_nxt = '0;
            addr_nxt  = o_vramAddr + ONE_A;
         end else begin
            sub_x_nxt = sub_x + ONE_S;
         end
         if (bar_cnt == BAR_MAX) begin
            bar_cnt_nxt = '0;
            bar_idx_nxt = bar_idx + 3'd1;
         end else begin
            bar_cnt_nxt = bar_cnt + ONE_B;
         end
      end
      if (last_px) begin
         if (sub_y_nxt == SUB_MAX) begin
            sub_y_nxt    = '0;
            row_base_nxt = row_base_nxt + ROW_STEP;
         end else begin
            sub_y_nxt = sub_y_nxt + ONE_S;
         end
      end
   end

   // Counter state and the registered VRAM address.
   always_ff @(posedge i_clkPixel) begin
      if (i_reset) begin
         row_base   <= '0;
         sub_x      <= '0;
         sub_y      <= '0;
         bar_cnt    <= '0;
         bar_idx    <= '0;
         mode_q     <= 1'b0;
         o_vramAddr <= '0;
      end else begin
         row_base   <= row_base_nxt;
         sub_x      <= sub_x_nxt;
         sub_y      <= sub_y_nxt;
         bar_cnt    <= bar_cnt_nxt;
         bar_idx    <= bar_idx_nxt;
         mode_q     <= mode_nxt;
         o_vramAddr <= addr_nxt;
      end
   end

   // Delay line carrying flags and syncs until the VRAM data arrives.
   always_ff @(posedge i_clkPixel) begin
      if (i_reset) begin
         p_act  <= '0;
         p_win  <= '0;
         p_hs   <= {P{HSYNC_IDLE}};
         p_vs   <= {P{VSYNC_IDLE}};
         p_fs   <= '0;
         p_mode <= '0;
         for (int i = 0; i < P; i++) p_bar[i] <= '0;
      end else begin
         p_act  <= {p_act[P-2:0], i_active};
         p_win  <= {p_win[P-2:0], in_win};
         p_hs   <= {p_hs[P-2:0], i_hSync};
         p_vs   <= {p_vs[P-2:0], i_vSync};
         p_fs   <= {p_fs[P-2:0], frame_start};
         p_mode <= {p_mode[P-2:0], mode_nxt};
         p_bar[0] <= bar_idx_nxt;
         for (int i = 1; i < P; i++) p_bar[i] <= p_bar[i-1];
      end
   end

   // Colour-bar lookup for the delayed bar index.
   always_comb begin
      bar_color = 8'h00;
      case (p_bar[P-1])
         3'd0:    bar_color = 8'hFF;
         3'd1:    bar_color = 8'hE0;
         3'd2:    bar_color = 8'h1C;
         3'd3:    bar_color = 8'h03;
         3'd4:    bar_color = 8'hFC;
         3'd5:    bar_color = 8'h1F;
         3'd6:    bar_color = 8'hE3;
         default: bar_color = 8'h00;
      endcase
   end

   // Pixel source: blank, border, bar or VRAM.
   always_comb begin
      pix = 8'h00;
      if (p_act[P-1]) begin
         if (!p_win[P-1]) begin
            pix = i_borderColor;
         end else if (p_mode[P-1]) begin
            pix = bar_color;
         end else begin
            pix = 8'(i_vramData);
         end
      end
   end

   // Output register keeps RGB, syncs and frame pulse aligned.
   always_ff @(posedge i_clkPixel) begin
      if (i_reset) begin
         o_red        <= '0;
         o_green      <= '0;
         o_blue       <= '0;
         o_hSync      <= HSYNC_IDLE;
         o_vSync      <= VSYNC_IDLE;
         o_frameStart <= 1'b0;
      end else begin
         o_red        <= pix[7:5];
         o_green      <= pix[4:2];
         o_blue       <= pix[1:0];
         o_hSync      <= p_hs[P-1];
         o_vSync      <= p_vs[P-1];
         o_frameStart <= p_fs[P-1];
      end
   end

endmodule

// File: tb/tb_vga_scaled_window.sv
// tb_vga_scaled_window: random raster stimulus against a formula-based
// model of the scaled window, border, bars and sync alignment.
module tb_vga_scaled_window;

   localparam int   SRC_W  = 160;
   localparam int   SRC_H  = 3;
   localparam int   SCALE  = 4;
   localparam int   WIN_X0 = 16;
   localparam int   WIN_Y0 = 2;
   localparam int   AW     = 15;
   localparam int   H_TOT  = 680;
   localparam int   H_ACT  = 672;
   localparam int   V_TOT  = 17;
   localparam int   V_ACT  = 15;
   localparam int   BAR_W  = SCALE * SRC_W / 8;
   localparam logic HS_IDLE = 1'b1;
   localparam logic VS_IDLE = 1'b0;

   logic          clk = 1'b0;
   logic          rst;
   logic          active;
   logic [15:0]   x;
   logic [15:0]   y;
   logic          hs;
   logic          vs;
   logic [7:0]    vram_data;
   logic          tp;
   logic [7:0]    border;
   logic [AW-1:0] vram_addr;
   logic [2:0]    red;
   logic [2:0]    green;
   logic [1:0]    blue;
   logic          o_hs;
   logic          o_vs;
   logic          o_fs;

   vga_scaled_window #(
      .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE),
      .WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0),
      .ADDR_WIDTH(AW), .DATA_WIDTH(8), .RAM_LATENCY(1),
      .HSYNC_IDLE(HS_IDLE), .VSYNC_IDLE(VS_IDLE)
   ) dut (
      .i_clkPixel(clk),
      .i_reset(rst),
      .i_active(active),
      .i_x(x),
      .i_y(y),
      .i_hSync(hs),
      .i_vSync(vs),
      .i_vramData(vram_data),
      .i_testPattern(tp),
      .i_borderColor(border),
      .o_vramAddr(vram_addr),
      .o_red(red),
      .o_green(green),
      .o_blue(blue),
      .o_hSync(o_hs),
      .o_vSync(o_vs),
      .o_frameStart(o_fs)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:(1<<AW)-1];
   logic [7:0] bars [8];

   // One-cycle VRAM read port.
   always @(posedge clk) vram_data <= mem[vram_addr];

   typedef struct {
      bit rst;
      bit act;
      bit win;
      bit hs;
      bit vs;
      bit fs;
      bit mode;
      bit ok;
      int addr;
      int bar;
   } rec_t;

   rec_t hist[$];
   int   checks = 0;
   int   errors = 0;
   int   m_addr = 0;
   bit   m_valid = 0;
   bit   m_mode = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (x=%0d y=%0d t=%0t)",
                  tag, got, exp, x, y, $time);
      end
   endtask

   function automatic rec_t reset_rec();
      rec_t r;
      r = '{default: 0};
      r.rst = 1'b1;
      r.hs  = HS_IDLE;
      r.vs  = VS_IDLE;
      return r;
   endfunction

   task automatic drive(input int xx, input int yy, input bit r);
      x      = 16'(xx);
      y      = 16'(yy);
      active = (xx < H_ACT) && (yy < V_ACT);
      hs     = 1'($urandom_range(0, 1));
      vs     = 1'($urandom_range(0, 1));
      border = 8'($urandom);
      rst    = r;
   endtask

   task automatic tick();
      rec_t r;
      rec_t e;
      int   xi;
      int   yi;
      logic [7:0] rgb;
      @(posedge clk);
      xi = int'(x);
      yi = int'(y);
      if (rst) begin
         r       = reset_rec();
         m_addr  = 0;
         m_valid = 0;
         m_mode  = 0;
         foreach (hist[i]) hist[i] = r;
      end else begin
         r     = '{default: 0};
         r.act = active;
         r.win = active && xi >= WIN_X0 && xi < WIN_X0 + SRC_W*SCALE
                 && yi >= WIN_Y0 && yi < WIN_Y0 + SRC_H*SCALE;
         r.hs  = hs;
         r.vs  = vs;
         r.fs  = (xi == 0) && (yi == 0);
         if (r.fs) begin
            m_valid = 1;
            m_mode  = tp;
         end
         if (r.win) begin
            m_addr = ((yi - WIN_Y0) / SCALE) * SRC_W + (xi - WIN_X0) / SCALE;
            r.bar  = (xi - WIN_X0) / BAR_W;
         end
         r.mode = m_mode;
         r.ok   = m_valid;
         r.addr = m_addr;
      end
      hist.push_back(r);
      if (hist.size() > 3) void'(hist.pop_front());
      #1;
      if (rst) check("reset_addr", 32'(vram_addr), 0);
      else if (m_valid) check("addr", 32'(vram_addr), 32'(m_addr));
      e   = hist[0];
      rgb = {red, green, blue};
      if (!e.act) check(e.rst ? "reset_rgb" : "blank_rgb", 32'(rgb), 0);
      else if (!e.win) check("border_rgb", 32'(rgb), 32'(border));
      else if (e.ok && e.mode) check("bar_rgb", 32'(rgb), 32'(bars[e.bar]));
      else if (e.ok) check("vram_rgb", 32'(rgb), 32'(mem[e.addr]));
      check("hsync", 32'(o_hs), 32'(e.hs));
      check("vsync", 32'(o_vs), 32'(e.vs));
      check("frame_start", 32'(o_fs), 32'(e.fs));
   endtask

   initial begin
      int rst_x;
      int rst_y;
      bars[0] = 8'hFF; bars[1] = 8'hE0; bars[2] = 8'h1C; bars[3] = 8'h03;
      bars[4] = 8'hFC; bars[5] = 8'h1F; bars[6] = 8'hE3; bars[7] = 8'h00;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 3; i++) hist.push_back(reset_rec());
      tp    = 1'b0;
      rst_x = WIN_X0 + int'($urandom_range(1, SRC_W*SCALE - 2));
      rst_y = WIN_Y0 + int'($urandom_range(1, SRC_H*SCALE - 2));
      for (int i = 0; i < 3; i++) begin
         drive(H_TOT - 3 + i, V_TOT - 1, 1'b1);
         tick();
      end
      for (int f = 0; f < 5; f++) begin
         for (int yy = 0; yy < V_TOT; yy++) begin
            for (int xx = 0; xx < H_TOT; xx++) begin
               drive(xx, yy, (f == 2) && (xx == rst_x) && (yy == rst_y));
               if (yy == 6 && xx == 300) begin
                  if (f == 1) tp = 1'b1;
                  if (f == 3) tp = 1'b0;
               end
               tick();
            end
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
